// File: rtl/mips_fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory request/response, decode redirect and the
// decode-facing instruction queue head.
interface mips_fetch_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) ();
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [OCC_W-1:0]  occupancy;

  // The fetch queue drives requests and the queue head.
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, occupancy,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, occupancy,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
    output out_ready
  );
endinterface

// File: rtl/mips_fetch_queue.sv
// Decoupled MIPS instruction fetch: credit-limited in-order memory requests, a DEPTH-entry
// instruction/PC queue, J predecode and decode-driven redirects that flush in-flight work.
module mips_fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst,
  mips_fetch_queue_if.master bus
);
  localparam int unsigned  PTR_W = $clog2(DEPTH);
  localparam int unsigned  OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W:0] LIMIT = DEPTH[OCC_W:0];
  localparam logic [5:0]   OP_J  = 6'b000010;

  logic [DATA_W-1:0] r_instr [DEPTH];
  logic [ADDR_W-1:0] r_pc    [DEPTH];
  logic [PTR_W-1:0]  r_rptr, r_wptr;
  logic [OCC_W-1:0]  r_count, r_outst, r_discard;
  logic [ADDR_W-1:0] r_fetch_pc, r_rsp_pc;

  logic              w_rsp_keep, w_jtake, w_push, w_pop, w_hs, w_credit;
  logic [OCC_W:0]    w_sum;
  logic [OCC_W-1:0]  w_outst_after;
  logic [ADDR_W-1:0] w_rsp_pc_inc, w_j_target;

  assign w_rsp_keep    = bus.imem_rsp_valid && (r_discard == '0);
  assign w_jtake       = w_rsp_keep && (bus.imem_rsp_data[31:26] == OP_J) && !bus.redirect_valid;
  assign w_push        = w_rsp_keep && !bus.redirect_valid;
  assign w_pop         = bus.out_valid && bus.out_ready && !bus.redirect_valid;
  assign w_sum         = {1'b0, r_count} + {1'b0, r_outst};
  assign w_credit      = w_sum < LIMIT;
  assign w_hs          = bus.imem_req_valid && bus.imem_req_ready;
  assign w_outst_after = r_outst - OCC_W'(bus.imem_rsp_valid);
  assign w_rsp_pc_inc  = r_rsp_pc + ADDR_W'(4);

  // J keeps the region bits of the delay-slot PC and replaces the low 28 bits.
  always_comb begin
    w_j_target       = w_rsp_pc_inc;
    w_j_target[27:0] = {bus.imem_rsp_data[25:0], 2'b00};
  end

  assign bus.imem_req_valid = rst && !bus.redirect_valid && !w_jtake && w_credit;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.out_valid      = (r_count != '0);
  assign bus.out_instr      = bus.out_valid ? r_instr[r_rptr] : '0;
  assign bus.out_pc         = bus.out_valid ? r_pc[r_rptr] : '0;
  assign bus.occupancy      = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wptr] <= bus.imem_rsp_data;
      r_pc[r_wptr]    <= r_rsp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
    end else begin
      r_outst <= r_outst + OCC_W'(w_hs) - OCC_W'(bus.imem_rsp_valid);
      if (bus.redirect_valid) begin
        // Everything still in flight belongs to the squashed path.
        r_fetch_pc <= bus.redirect_pc;
        r_rsp_pc   <= bus.redirect_pc;
        r_discard  <= w_outst_after;
        r_rptr     <= '0;
        r_wptr     <= '0;
        r_count    <= '0;
      end else begin
        if (w_jtake) begin
          r_fetch_pc <= w_j_target;
          r_rsp_pc   <= w_j_target;
          r_discard  <= w_outst_after;
        end else begin
          if (w_hs) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
          if (w_push) r_rsp_pc <= w_rsp_pc_inc;
          if (bus.imem_rsp_valid && (r_discard != '0)) r_discard <= r_discard - OCC_W'(1);
        end
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
        r_count <= r_count + OCC_W'(w_push) - OCC_W'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_mips_fetch_queue.sv
// Randomized bench for mips_fetch_queue: variable-latency memory model plus an architectural
// instruction-stream model that predicts every PC/word decode should receive.
module tb_mips_fetch_queue;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  mips_fetch_queue #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  req_t        pending[$];
  logic [31:0] popped[$];
  int          n_total, n_bad;
  int          cyc, last_due, lat_min, lat_max, ordy_pct, rrdy_pct, mem_mode;
  int          n_req, n_pops, first_valid;
  bit          redir_req;
  logic [31:0] redir_pc_g, exp_pc, first_req_addr, last_req_addr, s_req_addr;
  logic        s_req_valid, s_out_valid, s_rsp_j;
  logic [2:0]  s_occ;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit coin(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic bit is_j(input logic [31:0] w);
    return w[31:26] == 6'b000010;
  endfunction

  // Program image: mode 0 straight-line, mode 1 adds J 0x100 at 0x8, mode 2 sprinkles Js.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] t;
    if (mem_mode == 1 && a == 32'h8) return 32'h0800_0040;
    if (mem_mode == 2 && a[4:2] == 3'd5) begin
      t = (a * 32'd13 + 32'h40) & 32'h0000_0FFC;
      return {6'b000010, t[27:2]};
    end
    return {6'b001000, a[27:2]} ^ 32'h0015_A5A5;
  endfunction

  task automatic do_reset(input bit chk);
    rst = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    pending.delete();
    @(posedge clk);
    @(negedge clk);
    if (chk) begin
      check("rst_req_valid", bus.imem_req_valid, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_occupancy", bus.occupancy, 0);
      check("rst_out_pc", bus.out_pc, 0);
      check("rst_out_instr", bus.out_instr, 0);
    end
    rst         = 1'b1;
    cyc         = 0;
    last_due    = -1;
    exp_pc      = RESET_PC;
    redir_req   = 1'b0;
    n_req       = 0;
    n_pops      = 0;
    first_valid = -1;
    popped.delete();
  endtask

  // One clock cycle: drive inputs, sample just after, score, then advance past the edge.
  task automatic step();
    bit          rsp_fire, pop;
    logic [31:0] w;
    int          d;
    bus.redirect_valid = redir_req;
    bus.redirect_pc    = redir_pc_g;
    redir_req          = 1'b0;
    bus.out_ready      = coin(ordy_pct);
    bus.imem_req_ready = coin(rrdy_pct);
    rsp_fire           = (pending.size() > 0) && (pending[0].due <= cyc);
    bus.imem_rsp_valid = rsp_fire;
    if (rsp_fire) bus.imem_rsp_data = mem_word(pending[0].addr);
    else bus.imem_rsp_data = $urandom();
    #1;
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_out_valid = bus.out_valid;
    s_occ       = bus.occupancy;
    s_rsp_j     = rsp_fire && is_j(bus.imem_rsp_data);
    check("valid_vs_occ", bus.out_valid, bus.occupancy != 0);
    check("credit", (int'(bus.occupancy) + pending.size()) <= DEPTH, 1);
    if (bus.out_valid && first_valid < 0) first_valid = cyc;
    pop = bus.out_valid && bus.out_ready && !bus.redirect_valid;
    if (pop) begin
      w = mem_word(exp_pc);
      check("out_pc", bus.out_pc, exp_pc);
      check("out_instr", bus.out_instr, w);
      popped.push_back(bus.out_pc);
      n_pops++;
      if (is_j(w)) begin
        d      = 0;
        exp_pc = exp_pc + 32'd4;
        exp_pc = {exp_pc[31:28], w[25:0], 2'b00};
      end else begin
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (bus.redirect_valid) exp_pc = bus.redirect_pc;
    if (rsp_fire) void'(pending.pop_front());
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      if (n_req == 0) first_req_addr = bus.imem_req_addr;
      last_req_addr = bus.imem_req_addr;
      n_req++;
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pending.push_back('{addr: bus.imem_req_addr, due: d});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] tgt;
    n_total  = 0;
    n_bad    = 0;
    rrdy_pct = 100;
    redir_pc_g = '0;

    // Straight-line streaming with a 1-cycle memory.
    mem_mode = 0; lat_min = 1; lat_max = 1; ordy_pct = 100;
    do_reset(1'b1);
    repeat (14) step();
    check("t1_first_valid", first_valid, 2);
    check("t1_pops", n_pops, 12);

    // Decode stalled: exactly DEPTH requests, then one pop frees one credit.
    do_reset(1'b0);
    ordy_pct = 0;
    repeat (10) step();
    check("t2_nreq", n_req, DEPTH);
    check("t2_last_addr", last_req_addr, 32'hC);
    check("t2_occ_full", s_occ, DEPTH);
    check("t2_req_blocked", s_req_valid, 0);
    ordy_pct = 100;
    step();
    ordy_pct = 0;
    step();
    check("t2_req_again", s_req_valid, 1);
    check("t2_req_addr", s_req_addr, 32'h10);

    // J predecode with a 3-cycle memory: two younger responses dropped.
    do_reset(1'b0);
    mem_mode = 1; lat_min = 3; lat_max = 3; ordy_pct = 100;
    repeat (20) step();
    if (popped.size() >= 4) begin
      check("t3_j_pc", popped[2], 32'h8);
      check("t3_target_pc", popped[3], 32'h100);
    end else check("t3_pop_count", popped.size(), 4);

    // Redirect with 2 queued, 2 outstanding (one responding in the redirect cycle).
    do_reset(1'b0);
    mem_mode = 0; lat_min = 4; lat_max = 4; ordy_pct = 0;
    repeat (6) step();
    redir_req = 1'b1; redir_pc_g = 32'h200;
    step();
    check("t4_occ_before", s_occ, 2);
    check("t4_nreq", n_req, 4);
    step();
    check("t4_occ_flushed", s_occ, 0);
    ordy_pct = 100;
    repeat (12) step();
    if (popped.size() >= 1) check("t4_first_pc", popped[0], 32'h200);
    else check("t4_pop_count", popped.size(), 1);

    // Redirect coincident with a J response and a pop attempt.
    do_reset(1'b0);
    mem_mode = 1; lat_min = 1; lat_max = 1; ordy_pct = 100;
    repeat (3) step();
    redir_req = 1'b1; redir_pc_g = 32'h300;
    step();
    check("t5_pop_attempt", s_out_valid, 1);
    check("t5_rsp_is_j", s_rsp_j, 1);
    repeat (8) step();
    if (popped.size() >= 2) begin
      check("t5_pc0", popped[0], 32'h0);
      check("t5_after_redirect", popped[1], 32'h300);
    end else check("t5_pop_count", popped.size(), 2);

    // Reset mid-stream with two requests outstanding.
    do_reset(1'b0);
    mem_mode = 0; lat_min = 3; lat_max = 3; ordy_pct = 100;
    repeat (2) step();
    do_reset(1'b1);
    step();
    check("t6_req_valid", s_req_valid, 1);
    check("t6_first_addr", first_req_addr, RESET_PC);
    repeat (10) step();
    if (popped.size() >= 1) check("t6_first_pop", popped[0], RESET_PC);
    else check("t6_pop_count", popped.size(), 1);

    // Random traffic: variable latency, backpressure, Js and redirects (incl. PC wrap).
    do_reset(1'b0);
    mem_mode = 2; lat_min = 1; lat_max = 4; ordy_pct = 70; rrdy_pct = 80;
    redir_req = 1'b1; redir_pc_g = 32'hFFFF_FFF0;
    for (int i = 0; i < 3000; i++) begin
      if (coin(2)) begin
        tgt = $urandom_range(0, 1023);
        tgt = tgt << 2;
        if (coin(10)) tgt = tgt | 32'hFFFF_F000;
        redir_req  = 1'b1;
        redir_pc_g = tgt;
      end
      step();
    end
    check("rand_progress", n_pops > 300, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
